// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_pkg
//  Brief    : Shared widths, stall encodings, fetch FSM states and PC helpers
//             for the instruction-fetch stage.
//  Revision : 1.0  initial release
// ============================================================================
package if_fetch_pkg;

  // Bus widths shared with the ID stage and the pipeline controller
  localparam int C_STALL_BUS_WD = 6;   // stall vector
  localparam int C_BR_WD        = 33;  // {br_e, br_addr[31:0]}
  localparam int C_IF_TO_ID_WD  = 33;  // {ce, pc[31:0]}

  // Stall vector bit values
  localparam logic C_STOP    = 1'b1;
  localparam logic C_NO_STOP = 1'b0;

  // Address of the first fetch after reset (MIPS boot vector)
  localparam logic [31:0] C_RESET_PC_DEFAULT = 32'hbfc0_0000;

  // Fetch FSM
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request on the bus
    S_REQ  = 2'd1,  // request presented, waiting for addr_ok
    S_WAIT = 2'd2,  // request accepted, waiting for data_ok
    S_HOLD = 2'd3   // instruction buffered for ID
  } fetch_state_t;

  // PC arithmetic is 32-bit unsigned and wraps
  function automatic logic [31:0] pc_add4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] pc_sub4(input logic [31:0] pc);
    return pc - 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_if
//  Brief    : Instruction SRAM request/response bus (SRAM-like, split
//             address and data handshakes).
//  Revision : 1.0  initial release
// ============================================================================
interface if_fetch_if;

  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  // Fetch unit side
  modport master (
    output inst_sram_req,
    output inst_sram_addr,
    output inst_sram_wen,
    output inst_sram_wdata,
    input  inst_sram_addr_ok,
    input  inst_sram_data_ok,
    input  inst_sram_rdata
  );

  // Memory side
  modport slave (
    input  inst_sram_req,
    input  inst_sram_addr,
    input  inst_sram_wen,
    input  inst_sram_wdata,
    output inst_sram_addr_ok,
    output inst_sram_data_ok,
    output inst_sram_rdata
  );

endinterface
`default_nettype wire

// File: rtl/if_redirect_buf.sv
`default_nettype none
// ============================================================================
//  Module   : if_redirect_buf
//  Brief    : One-entry redirect buffer. A redirect that arrives while the PC
//             is stalled is held (latest wins) and replayed when the stall
//             clears. Compiled only with IF_REDIRECT_BUF_EN defined.
//  Revision : 1.0  initial release
// ============================================================================
`ifdef IF_REDIRECT_BUF_EN
module if_redirect_buf (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        stop,      // PC stage stalled this cycle
  input  wire logic        br_e,
  input  wire logic [31:0] br_addr,
  output logic             eff_e,     // redirect to apply this cycle
  output logic [31:0]      eff_addr
);

  logic        r_valid;
  logic [31:0] r_addr;

  // Capture redirects seen during a stall; drop the entry once replayed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (stop) begin
      if (br_e) begin
        r_valid <= 1'b1;
        r_addr  <= br_addr;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  // A live redirect is newer than a buffered one, so it takes priority
  assign eff_e    = ~stop & (br_e | r_valid);
  assign eff_addr = br_e ? br_addr : r_addr;

endmodule
`endif
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch
//  Brief    : Instruction fetch stage. Issues one SRAM read at a time,
//             buffers the returned word in a single slot for ID, and
//             handles redirects from ID by retargeting or cancelling the
//             in-flight read.
//  Config   : IF_REDIRECT_BUF_EN - hold redirects that arrive during a PC
//             stall and apply them when the stall clears.
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC_DEFAULT
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic [C_STALL_BUS_WD-1:0] stall,
  input  wire logic [C_BR_WD-1:0]        br_bus,
  output logic                           stallreq,
  output logic [C_IF_TO_ID_WD-1:0]       if_to_id_bus,
  output logic [31:0]                    fetch_inst,
  if_fetch_if.master                     sram
);

  fetch_state_t r_state, w_state_nxt;

  // r_pc is the pc of the most recently accepted fetch; the following fetch
  // targets r_pc+4. A redirect that cannot issue immediately is recorded as
  // r_pc = target-4 so the normal sequential step lands on the target.
  logic [31:0] r_pc,        w_pc_nxt;
  logic [31:0] r_addr,      w_addr_nxt;
  logic        r_cancel,    w_cancel_nxt;
  logic        r_hold_valid, w_hold_valid_nxt;
  logic [31:0] r_hold_pc,   w_hold_pc_nxt;
  logic [31:0] r_hold_inst, w_hold_inst_nxt;

  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic        w_pc_run;
  logic        w_id_take;
  logic        w_redirect;
  logic [31:0] w_seq_pc;
  logic        w_unused;

  assign w_pc_run  = (stall[0] == C_NO_STOP);
  assign w_id_take = (stall[1] == C_NO_STOP);
  assign w_unused  = ^stall[C_STALL_BUS_WD-1:2];

`ifdef IF_REDIRECT_BUF_EN
  if_redirect_buf u_redirect_buf (
    .clk      (clk),
    .rst      (rst),
    .stop     (~w_pc_run),
    .br_e     (br_bus[32]),
    .br_addr  (br_bus[31:0]),
    .eff_e    (w_br_e),
    .eff_addr (w_br_addr)
  );
`else
  assign w_br_e    = br_bus[32];
  assign w_br_addr = br_bus[31:0];
`endif

  // A redirect only takes effect while the PC stage is running
  assign w_redirect = w_br_e & w_pc_run;
  assign w_seq_pc   = w_redirect ? w_br_addr : pc_add4(r_pc);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC - 32'd4;
      r_addr       <= '0;
      r_cancel     <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_pc    <= '0;
      r_hold_inst  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_addr       <= w_addr_nxt;
      r_cancel     <= w_cancel_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_hold_inst  <= w_hold_inst_nxt;
    end
  end

  // Next-state and datapath update for the fetch FSM
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_addr_nxt       = r_addr;
    w_cancel_nxt     = r_cancel;
    w_hold_valid_nxt = r_hold_valid;
    w_hold_pc_nxt    = r_hold_pc;
    w_hold_inst_nxt  = r_hold_inst;

    case (r_state)
      S_IDLE: begin
        if (w_pc_run) begin
          w_state_nxt = S_REQ;
          w_addr_nxt  = w_seq_pc;
        end
      end

      S_REQ: begin
        if (sram.inst_sram_addr_ok) begin
          w_state_nxt = S_WAIT;
          if (w_redirect) begin
            // Accepted read is now stale; its data will be dropped
            w_cancel_nxt = 1'b1;
            w_pc_nxt     = pc_sub4(w_br_addr);
          end else begin
            w_pc_nxt = r_addr;
          end
        end else if (w_redirect) begin
          // Not yet accepted: simply retarget the pending request
          w_addr_nxt = w_br_addr;
        end
      end

      S_WAIT: begin
        if (w_redirect) begin
          w_pc_nxt = pc_sub4(w_br_addr);
        end
        if (sram.inst_sram_data_ok) begin
          if (r_cancel || w_redirect) begin
            w_cancel_nxt = 1'b0;
            if (w_pc_run) begin
              w_state_nxt = S_REQ;
              w_addr_nxt  = w_seq_pc;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt      = S_HOLD;
            w_hold_valid_nxt = 1'b1;
            w_hold_pc_nxt    = r_pc;
            w_hold_inst_nxt  = sram.inst_sram_rdata;
          end
        end else if (w_redirect) begin
          w_cancel_nxt = 1'b1;
        end
      end

      S_HOLD: begin
        if (w_redirect) begin
          // Buffered instruction is on the wrong path
          w_hold_valid_nxt = 1'b0;
          w_state_nxt      = S_REQ;
          w_addr_nxt       = w_br_addr;
        end else if (w_id_take) begin
          w_hold_valid_nxt = 1'b0;
          if (w_pc_run) begin
            w_state_nxt = S_REQ;
            w_addr_nxt  = w_seq_pc;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bus and ID-side outputs come straight from registers
  assign sram.inst_sram_req   = (r_state == S_REQ);
  assign sram.inst_sram_addr  = r_addr;
  assign sram.inst_sram_wen   = 4'b0;
  assign sram.inst_sram_wdata = 32'b0;

  assign stallreq     = ~r_hold_valid;
  assign if_to_id_bus = {r_hold_valid, r_hold_pc};
  assign fetch_inst   = r_hold_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch
//  Brief    : Self-checking bench for if_fetch with a randomised SRAM
//             responder and a program-order reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [C_STALL_BUS_WD-1:0] stall;
  logic [C_BR_WD-1:0]        br_bus;
  logic                      stallreq;
  logic [C_IF_TO_ID_WD-1:0]  if_to_id_bus;
  logic [31:0]               fetch_inst;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_bus       (br_bus),
    .stallreq     (stallreq),
    .if_to_id_bus (if_to_id_bus),
    .fetch_inst   (fetch_inst),
    .sram         (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // memory responder state
  bit          slave_auto = 1'b1;
  int          p_addr = 100;
  int          p_data = 100;
  bit          outstanding = 1'b0;
  logic [31:0] out_addr = '0;

  // reference model: the pc ID must see next, in program order
  logic [31:0] exp_next = RST_PC;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          consumed = 0;

  // previous-cycle bus observations
  bit          prev_valid = 1'b0;
  bit          prev_req, prev_aok, prev_redir, prev_run;
  logic [31:0] prev_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h83c1_0001;   // inst_of(bfc00000) = 3c010001
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory responses, check against the model, advance.
  task automatic tick();
    logic        ce, run, redir;
    logic [31:0] pc, raddr;
    ce  = if_to_id_bus[32];
    pc  = if_to_id_bus[31:0];
    run = (stall[0] == C_NO_STOP);
    if (slave_auto) begin
      bus.inst_sram_addr_ok = bus.inst_sram_req && (int'($urandom_range(99)) < p_addr);
      bus.inst_sram_data_ok = outstanding && (int'($urandom_range(99)) < p_data);
      bus.inst_sram_rdata   = bus.inst_sram_data_ok ? inst_of(out_addr) : $urandom;
    end
`ifdef IF_REDIRECT_BUF_EN
    redir = run && (br_bus[32] || pend);
    raddr = br_bus[32] ? br_bus[31:0] : pend_addr;
    if (!run) begin
      if (br_bus[32]) begin
        pend = 1'b1;
        pend_addr = br_bus[31:0];
      end
    end else begin
      pend = 1'b0;
    end
`else
    redir = run && br_bus[32];
    raddr = br_bus[31:0];
`endif
    chk1("stallreq", stallreq, ~ce);
    chk32("wen", {28'b0, bus.inst_sram_wen}, 32'b0);
    chk32("wdata", bus.inst_sram_wdata, 32'b0);
    if (ce) begin
      chk32("pc_order", pc, exp_next);
      chk32("inst", fetch_inst, inst_of(pc));
    end
    if (bus.inst_sram_req) chk1("one_outstanding", outstanding, 1'b0);
    if (prev_valid && bus.inst_sram_req) begin
      if (prev_req && !prev_aok) begin
        if (!prev_redir) chk32("addr_stable", bus.inst_sram_addr, prev_addr);
      end else begin
        chk1("issue_while_stopped", prev_run, 1'b1);
      end
    end
    if (redir) begin
      exp_next = raddr;
    end else if (ce && stall[1] == C_NO_STOP) begin
      exp_next = pc + 32'd4;
      consumed++;
    end
    prev_valid = 1'b1;
    prev_req   = bus.inst_sram_req;
    prev_aok   = bus.inst_sram_addr_ok;
    prev_redir = redir;
    prev_run   = run;
    prev_addr  = bus.inst_sram_addr;
    if (bus.inst_sram_data_ok) outstanding = 1'b0;
    if (bus.inst_sram_req && bus.inst_sram_addr_ok) begin
      outstanding = 1'b1;
      out_addr    = bus.inst_sram_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ce(input string tag);
    int n = 0;
    while (if_to_id_bus[32] !== 1'b1 && n < 40) begin tick(); n++; end
    chk1(tag, if_to_id_bus[32], 1'b1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.inst_sram_req !== 1'b1 && n < 40) begin tick(); n++; end
    chk1(tag, bus.inst_sram_req, 1'b1);
  endtask

  task automatic wait_wait(input string tag);
    int n = 0;
    while (!(outstanding && !bus.inst_sram_req) && n < 40) begin tick(); n++; end
    chk1(tag, outstanding, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_req"}, bus.inst_sram_req, 1'b0);
    chk32({tag, "_addr"}, bus.inst_sram_addr, 32'b0);
    chk1({tag, "_ce"}, if_to_id_bus[32], 1'b0);
    chk32({tag, "_pc"}, if_to_id_bus[31:0], 32'b0);
    chk32({tag, "_inst"}, fetch_inst, 32'b0);
    chk1({tag, "_stallreq"}, stallreq, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base, hpc, hinst;
    rst = 1'b1;
    stall = '0;
    br_bus = '0;
    bus.inst_sram_addr_ok = 1'b0;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // first fetch with single-cycle handshakes
    chk1("idle_after_reset", bus.inst_sram_req, 1'b0);
    tick();
    chk1("first_req", bus.inst_sram_req, 1'b1);
    chk32("first_addr", bus.inst_sram_addr, RST_PC);
    wait_ce("first_ce");
    chk32("first_pc", if_to_id_bus[31:0], 32'hbfc0_0000);
    chk32("first_inst", fetch_inst, 32'h3c01_0001);
    chk1("first_stallreq", stallreq, 1'b0);

    // back-to-back sequential fetches, each shown once
    for (int k = 0; k < 3; k++) begin
      wait_ce("seq_ce");
      chk32("seq_pc", if_to_id_bus[31:0], RST_PC + 32'(4 * k));
      tick();
      chk1("seq_once", if_to_id_bus[32], 1'b0);
    end

    // ID stall keeps the slot and issues nothing
    wait_ce("hold_ce");
    hpc = if_to_id_bus[31:0];
    hinst = fetch_inst;
    stall[1] = C_STOP;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("hold_ce_kept", if_to_id_bus[32], 1'b1);
      chk32("hold_pc_kept", if_to_id_bus[31:0], hpc);
      chk32("hold_inst_kept", fetch_inst, hinst);
      chk1("hold_no_req", bus.inst_sram_req, 1'b0);
    end
    stall = '0;

    // redirect while waiting for data: response dropped
    p_data = 0;
    wait_wait("wait_state");
    br_bus = {1'b1, 32'hbfc0_0100};
    tick();
    br_bus = '0;
    p_data = 100;
    wait_req("cancel_req");
    chk32("cancel_addr", bus.inst_sram_addr, 32'hbfc0_0100);
    wait_ce("cancel_ce");
    chk32("cancel_pc", if_to_id_bus[31:0], 32'hbfc0_0100);

    // redirect before addr_ok: pending request retargets
    p_addr = 0;
    wait_req("req_state");
    br_bus = {1'b1, 32'hbfc0_0300};
    tick();
    br_bus = '0;
    chk1("retarget_req", bus.inst_sram_req, 1'b1);
    chk32("retarget_addr", bus.inst_sram_addr, 32'hbfc0_0300);
    p_addr = 100;
    wait_ce("retarget_ce");
    chk32("retarget_pc", if_to_id_bus[31:0], 32'hbfc0_0300);

    // redirect coincident with data_ok
    p_data = 0;
    wait_wait("wait_state2");
    p_data = 100;
    br_bus = {1'b1, 32'hbfc0_0400};
    tick();
    br_bus = '0;
    wait_ce("dok_redir_ce");
    chk32("dok_redir_pc", if_to_id_bus[31:0], 32'hbfc0_0400);

    // redirect coincident with addr_ok
    p_addr = 0;
    wait_req("req_state2");
    p_addr = 100;
    br_bus = {1'b1, 32'hbfc0_0500};
    tick();
    br_bus = '0;
    wait_ce("aok_redir_ce");
    chk32("aok_redir_pc", if_to_id_bus[31:0], 32'hbfc0_0500);

    // redirect in HOLD to the top of memory, then wrap to zero
    wait_ce("wrap_hold");
    br_bus = {1'b1, 32'hffff_fffc};
    tick();
    br_bus = '0;
    chk1("hold_invalidated", if_to_id_bus[32], 1'b0);
    wait_ce("wrap_ce0");
    chk32("wrap_pc0", if_to_id_bus[31:0], 32'hffff_fffc);
    tick();
    wait_ce("wrap_ce1");
    chk32("wrap_pc1", if_to_id_bus[31:0], 32'h0000_0000);

    // redirect pulse during a PC stall
    base = if_to_id_bus[31:0];
    stall = 6'b000001;
    tick();
    tick();
    chk1("stop_no_req0", bus.inst_sram_req, 1'b0);
    br_bus = {1'b1, 32'hbfc0_0200};
    tick();
    br_bus = '0;
    chk1("stop_no_req1", bus.inst_sram_req, 1'b0);
    tick();
    chk1("stop_no_req2", bus.inst_sram_req, 1'b0);
    stall = '0;
    wait_ce("stop_ce");
`ifdef IF_REDIRECT_BUF_EN
    chk32("stop_pulse_pc", if_to_id_bus[31:0], 32'hbfc0_0200);
`else
    chk32("stop_pulse_pc", if_to_id_bus[31:0], base + 32'd4);
`endif

    // asynchronous reset while waiting for data
    p_data = 0;
    wait_wait("wait_state3");
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    outstanding = 1'b0;
    exp_next = RST_PC;
    pend = 1'b0;
    prev_valid = 1'b0;
    slave_auto = 1'b0;
    bus.inst_sram_addr_ok = 1'b0;
    bus.inst_sram_data_ok = 1'b1;
    bus.inst_sram_rdata   = 32'hdead_beef;
    tick();
    chk1("late_dok_ignored", if_to_id_bus[32], 1'b0);
    bus.inst_sram_data_ok = 1'b0;
    slave_auto = 1'b1;
    p_data = 100;
    wait_req("restart_req");
    chk32("restart_addr", bus.inst_sram_addr, RST_PC);
    wait_ce("restart_ce");
    chk32("restart_pc", if_to_id_bus[31:0], RST_PC);

    // randomised traffic checked against the program-order model
    p_addr = 60;
    p_data = 60;
    consumed = 0;
    for (int i = 0; i < 800; i++) begin
      stall = '0;
      stall[0] = ($urandom_range(7) == 0);
      stall[1] = ($urandom_range(5) == 0);
      if ($urandom_range(11) == 0) begin
        if ($urandom_range(4) == 0) br_bus = {1'b1, 32'hffff_fff8};
        else br_bus = {1'b1, 20'hbfc00, 10'($urandom_range(1023)), 2'b00};
      end else begin
        br_bus = '0;
      end
      tick();
    end
    stall = '0;
    br_bus = '0;
    chk1("random_progress", consumed > 40, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc0_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall  input  `StallBus  pipeline stall vector; stall[0] holds the PC, stall[1] holds IF->ID.
REQ-005 br_bus  input  `BR_WD  {br_e, br_addr[31:0]}, a redirect request from ID.
REQ-006 stallreq  output  1  high while no fetched instruction is ready for ID.
REQ-007 if_to_id_bus  output  `IF_TO_ID_WD  {ce, pc[31:0]}, ce=1 only when the slot holds a valid instruction.
REQ-008 fetch_inst  output  32  instruction word paired with if_to_id_bus.pc.
REQ-009 inst_sram_req  output  1  request valid.
REQ-010 inst_sram_addr  output  32  fetch address, stable while req=1 and addr_ok=0.
REQ-011 inst_sram_wen  output  4  tied to 4'b0.
REQ-012 inst_sram_wdata  output  32  tied to 32'b0.
REQ-013 inst_sram_addr_ok  input  1  request accepted this cycle when req=1.
REQ-014 inst_sram_data_ok  input  1  rdata valid this cycle for the oldest accepted request.
REQ-015 inst_sram_rdata  input  32  returned instruction word.

Function
REQ-016 FSM states: IDLE (no request), REQ (req=1, awaiting addr_ok), WAIT (accepted, awaiting data_ok), HOLD (instruction buffered for ID).
REQ-017 IDLE->REQ the cycle after reset release, with addr=next_pc; REQ->WAIT on addr_ok; WAIT->HOLD on data_ok (capture pc, rdata, valid=1); HOLD->REQ when consumed.
REQ-018 The HOLD slot is consumed when stall[1]==`NoStop; stall[1]==`Stop keeps the slot and outputs unchanged.
REQ-019 next_pc = buffered pc+4 on a normal advance; no request issues while stall[0]==`Stop; at most one request outstanding.
REQ-020 Redirect (br_e=1 with stall[0]==`NoStop): next_pc=br_addr; HOLD slot invalidated the same cycle; the next request goes to br_addr.
REQ-021 Redirect in REQ before addr_ok: addr switches to br_addr the next cycle; no extra transaction.
REQ-022 Redirect in WAIT, or coincident with addr_ok: set a cancel flag; the data_ok response for that request is discarded; then REQ to br_addr.
REQ-023 Redirect coincident with data_ok: the returned word is discarded, not buffered.
REQ-024 stallreq = ~hold_valid; ce = hold_valid; fetch_inst = hold_inst; combinational from the slot.
REQ-025 Arithmetic is 32-bit unsigned with wrap-around: 32'hffff_fffc+4 = 0.

Reset
REQ-026 rst forces IDLE, cancel=0, hold_valid=0, pc=RESET_PC-4, and all outputs to 0 except stallreq=1, with no clock required.
REQ-027 Reset mid-transaction drops any outstanding request; a late data_ok after reset is ignored.

Configuration
REQ-028 Macro IF_REDIRECT_BUF_EN: when defined, a br_e arriving while stall[0]==`Stop is latched in a 1-entry redirect buffer (the latest wins) and applied when the stall clears.
REQ-029 When IF_REDIRECT_BUF_EN is undefined, br_e is honoured only when stall[0]==`NoStop, and ID holds br_bus across stalls.

Structure
REQ-030 FSM state encoding, RESET_PC default and the bus widths (`IF_TO_ID_WD, `BR_WD, `StallBus) live in the shared defines package.
REQ-031 A single sub-module, if_redirect_buf, implements the REQ-028 buffer; it is instantiated only under IF_REDIRECT_BUF_EN.

Verification
REQ-032 Reset release, addr_ok and data_ok at 1-cycle latency, rdata=32'h3c01_0001 -> addr 32'hbfc0_0000, then ce=1, pc=32'hbfc0_0000, fetch_inst=32'h3c01_0001, stallreq=0.
REQ-033 Back-to-back fetches with stall=0 -> pc sequence bfc00000, bfc00004, bfc00008, each presented exactly once.
REQ-034 br_e=1, br_addr=32'hbfc0_0100, while in WAIT -> that response is discarded; next addr=32'hbfc0_0100; no ce=1 for the cancelled pc.
REQ-035 stall[1]=Stop for 3 cycles while in HOLD -> if_to_id_bus and fetch_inst stable; no new request issued.
REQ-036 With IF_REDIRECT_BUF_EN defined, br_e pulsed for 1 cycle during stall[0]=Stop, br_addr=32'hbfc0_0200 -> after the stall clears, addr=32'hbfc0_0200; undefined -> pulse ignored.
REQ-037 rst asserted asynchronously mid-WAIT -> outputs reset immediately; a data_ok arriving next cycle is ignored; the fetch restarts at 32'hbfc0_0000.
